// File: rtl/mem_if_pkg.sv
// Shared types and defaults for the memory-control handshake responder.
package mem_if_pkg;

  localparam int AW_DEF     = 15;
  localparam int DW_DEF     = 15;
  localparam int WR_LAT_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    RESP
  } state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with write enable and a registered, enabled read port.
module mem_array #(
  parameter int DEPTH = 256,
  parameter int DW    = 15,
  parameter int IW    = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [IW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  // NOTE: the array and its read register carry no reset; contents must survive rst and a reset would prevent RAM mapping.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: captures address/data, performs timed writes and
// read-backs on a private RAM, and counts completed write sweeps.
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int DEPTH  = 256,
  parameter int WR_LAT = WR_LAT_DEF,
  parameter int PASS_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_a,
  input  logic [AW-1:0]     addr_in,
  input  logic              load_d,
  input  logic [DW-1:0]     data_in,
  input  logic              write,
  input  logic              read,
  output logic              done,
  output logic [DW-1:0]     rd_data,
  output logic              busy,
  output logic              err,
  output logic              finish,
  output logic [PASS_W-1:0] pass
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
  localparam logic [AW:0]   DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [IW-1:0] LAST_W  = IW'(DEPTH - 1);
  localparam logic [LW-1:0] LAT_INI = LW'(WR_LAT - 1);

  state_t              r_state;
  logic [AW-1:0]       r_addr_q;
  logic [DW-1:0]       r_data_q;
  logic                r_a_valid;
  logic                r_d_valid;
  logic [LW-1:0]       r_lat;
  logic [IW-1:0]       r_wcount;
  logic [PASS_W-1:0]   r_pass;
  logic                r_done;
  logic                r_err;
  logic                r_finish;
  logic                r_busy;
  logic                r_rd_zero;

  logic                w_oor;
  logic                w_we;
  logic                w_re;
  logic [DW-1:0]       w_ram_q;

  // Operands are frozen while busy, so the range check can look at addr_q directly.
  assign w_oor = !({1'b0, r_addr_q} < DEPTH_V);
  assign w_we  = (r_state == WRITE) && (r_lat == '0) && !w_oor;
  assign w_re  = (r_state == READ);

  mem_array #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .IW    (IW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (r_addr_q[IW-1:0]),
    .i_wdata (r_data_q),
    .o_rdata (w_ram_q)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_addr_q  <= '0;
      r_data_q  <= '0;
      r_a_valid <= 1'b0;
      r_d_valid <= 1'b0;
      r_lat     <= '0;
      r_wcount  <= '0;
      r_pass    <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_finish  <= 1'b0;
      r_busy    <= 1'b0;
      r_rd_zero <= 1'b1;
    end else begin
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_finish <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (load_a) begin
            r_addr_q  <= addr_in;
            r_a_valid <= 1'b1;
          end
          if (load_d) begin
            r_data_q  <= data_in;
            r_d_valid <= 1'b1;
          end
          if (write && r_a_valid && r_d_valid) begin
            r_state <= WRITE;
            r_busy  <= 1'b1;
            r_lat   <= LAT_INI;
          end else if (write) begin
            r_err <= 1'b1;
          end else if (read && r_a_valid) begin
            r_state <= READ;
            r_busy  <= 1'b1;
          end else if (read) begin
            r_err <= 1'b1;
          end
        end
        WRITE: begin
          if (write || read) r_err <= 1'b1;
          if (r_lat == '0) begin
            r_state   <= RESP;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_a_valid <= 1'b0;
            r_d_valid <= 1'b0;
            if (w_oor) begin
              r_err <= 1'b1;
            end else if (r_wcount == LAST_W) begin
              r_wcount <= '0;
              r_finish <= 1'b1;
              if (r_pass != '1) r_pass <= r_pass + 1'b1;
            end else begin
              r_wcount <= r_wcount + 1'b1;
            end
          end else begin
            r_lat <= r_lat - 1'b1;
          end
        end
        READ: begin
          if (write || read || w_oor) r_err <= 1'b1;
          r_state   <= RESP;
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_a_valid <= 1'b0;
          r_rd_zero <= w_oor;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // The RAM read register only updates on reads, so it holds the last result by itself.
  assign rd_data = r_rd_zero ? '0 : w_ram_q;
  assign done    = r_done;
  assign busy    = r_busy;
  assign err     = r_err;
  assign finish  = r_finish;
  assign pass    = r_pass;

endmodule

// File: tb/tb_mem_responder.sv
// Drives two responders (DEPTH 256 and 4) with shared stimulus and checks both
// against a transaction-level model of captured operands, memory and sweep counts.
module tb_mem_responder;

  localparam int AW     = 15;
  localparam int DW     = 15;
  localparam int WR_LAT = 2;
  localparam int PASS_W = 4;
  localparam int NDUT   = 2;
  localparam int PMAX   = (1 << PASS_W) - 1;

  logic clk, rst;
  logic load_a, load_d, write, read;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] data_in;

  logic              done_o   [NDUT];
  logic              busy_o   [NDUT];
  logic              err_o    [NDUT];
  logic              finish_o [NDUT];
  logic [DW-1:0]     rd_o     [NDUT];
  logic [PASS_W-1:0] pass_o   [NDUT];

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: captured operands are common, memory and counters per instance.
  bit          m_av, m_dv;
  int          m_addr, m_data;
  logic [DW-1:0] m_mem   [NDUT][256];
  bit          m_known [NDUT][256];
  int          m_wcount [NDUT];
  int          m_pass   [NDUT];
  int          m_rd     [NDUT];
  bit          m_rd_known [NDUT];

  mem_responder #(.AW(AW), .DW(DW), .DEPTH(256), .WR_LAT(WR_LAT), .PASS_W(PASS_W)) dut_a (
    .clk(clk), .rst(rst), .load_a(load_a), .addr_in(addr_in), .load_d(load_d),
    .data_in(data_in), .write(write), .read(read), .done(done_o[0]), .rd_data(rd_o[0]),
    .busy(busy_o[0]), .err(err_o[0]), .finish(finish_o[0]), .pass(pass_o[0])
  );

  mem_responder #(.AW(AW), .DW(DW), .DEPTH(4), .WR_LAT(WR_LAT), .PASS_W(PASS_W)) dut_b (
    .clk(clk), .rst(rst), .load_a(load_a), .addr_in(addr_in), .load_d(load_d),
    .data_in(data_in), .write(write), .read(read), .done(done_o[1]), .rd_data(rd_o[1]),
    .busy(busy_o[1]), .err(err_o[1]), .finish(finish_o[1]), .pass(pass_o[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of test, required end before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic int depth_of(int k);
    return (k == 0) ? 256 : 4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(string tag, bit e_done, bit e_busy, bit e_err);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("%s_done%0d", tag, k), 32'(done_o[k]), 32'(e_done));
      check($sformatf("%s_busy%0d", tag, k), 32'(busy_o[k]), 32'(e_busy));
      check($sformatf("%s_err%0d",  tag, k), 32'(err_o[k]),  32'(e_err));
    end
  endtask

  task automatic model_reset();
    m_av = 0;
    m_dv = 0;
    for (int k = 0; k < NDUT; k++) begin
      m_wcount[k]   = 0;
      m_pass[k]     = 0;
      m_rd[k]       = 0;
      m_rd_known[k] = 1;
    end
  endtask

  task automatic do_reset(string tag);
    rst = 1'b1;
    tick();
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("%s_rst_done%0d", tag, k), 32'(done_o[k]), 0);
      check($sformatf("%s_rst_busy%0d", tag, k), 32'(busy_o[k]), 0);
      check($sformatf("%s_rst_err%0d", tag, k), 32'(err_o[k]), 0);
      check($sformatf("%s_rst_fin%0d", tag, k), 32'(finish_o[k]), 0);
      check($sformatf("%s_rst_rd%0d", tag, k), 32'(rd_o[k]), 0);
      check($sformatf("%s_rst_pass%0d", tag, k), 32'(pass_o[k]), 0);
    end
    rst = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic load(bit la, int a, bit ld, int d);
    load_a  = la;
    addr_in = a[AW-1:0];
    load_d  = ld;
    data_in = d[DW-1:0];
    tick();
    load_a = 1'b0;
    load_d = 1'b0;
    if (la) begin m_addr = a; m_av = 1; end
    if (ld) begin m_data = d; m_dv = 1; end
    check_flags("load", 0, 0, 0);
  endtask

  // Called in the cycle where the write response is due.
  task automatic write_resp(string tag);
    for (int k = 0; k < NDUT; k++) begin
      bit oor, fin;
      oor = (m_addr >= depth_of(k));
      fin = 0;
      if (!oor) begin
        m_mem[k][m_addr]   = m_data[DW-1:0];
        m_known[k][m_addr] = 1;
        if (m_wcount[k] == depth_of(k) - 1) begin
          m_wcount[k] = 0;
          fin = 1;
          if (m_pass[k] < PMAX) m_pass[k]++;
        end else begin
          m_wcount[k]++;
        end
      end
      check($sformatf("%s_wdone%0d", tag, k), 32'(done_o[k]), 1);
      check($sformatf("%s_werr%0d", tag, k), 32'(err_o[k]), 32'(oor));
      check($sformatf("%s_wbusy%0d", tag, k), 32'(busy_o[k]), 0);
      check($sformatf("%s_wfin%0d", tag, k), 32'(finish_o[k]), 32'(fin));
      check($sformatf("%s_wpass%0d", tag, k), 32'(pass_o[k]), 32'(m_pass[k]));
      if (m_rd_known[k]) check($sformatf("%s_rdhold%0d", tag, k), 32'(rd_o[k]), 32'(m_rd[k]));
    end
    m_av = 0;
    m_dv = 0;
  endtask

  task automatic read_resp(string tag);
    for (int k = 0; k < NDUT; k++) begin
      bit oor;
      oor = (m_addr >= depth_of(k));
      check($sformatf("%s_rdone%0d", tag, k), 32'(done_o[k]), 1);
      check($sformatf("%s_rerr%0d", tag, k), 32'(err_o[k]), 32'(oor));
      check($sformatf("%s_rbusy%0d", tag, k), 32'(busy_o[k]), 0);
      if (oor) begin
        m_rd[k] = 0;
        m_rd_known[k] = 1;
      end else begin
        m_rd[k] = int'(m_mem[k][m_addr]);
        m_rd_known[k] = m_known[k][m_addr];
      end
      if (m_rd_known[k]) check($sformatf("%s_rdata%0d", tag, k), 32'(rd_o[k]), 32'(m_rd[k]));
    end
    m_av = 0;
  endtask

  task automatic strobe(bit wr, bit rd, string tag);
    bit acc_w, acc_r;
    acc_w = wr && m_av && m_dv;
    acc_r = !wr && rd && m_av;
    write = wr;
    read  = rd;
    tick();
    write = 1'b0;
    read  = 1'b0;
    if (acc_w) begin
      for (int c = 1; c <= WR_LAT; c++) begin
        check_flags($sformatf("%s_wlat%0d", tag, c), 0, 1, 0);
        tick();
      end
      write_resp(tag);
      tick();
      check_flags($sformatf("%s_wpost", tag), 0, 0, 0);
    end else if (acc_r) begin
      check_flags($sformatf("%s_rlat", tag), 0, 1, 0);
      tick();
      read_resp(tag);
      tick();
      check_flags($sformatf("%s_rpost", tag), 0, 0, 0);
    end else if (wr || rd) begin
      check_flags($sformatf("%s_rej", tag), 0, 0, 1);
      tick();
      check_flags($sformatf("%s_rejpost", tag), 0, 0, 0);
    end else begin
      check_flags($sformatf("%s_none", tag), 0, 0, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    load_a = 1'b0; load_d = 1'b0; write = 1'b0; read = 1'b0;
    addr_in = '0; data_in = '0;
    for (int k = 0; k < NDUT; k++)
      for (int i = 0; i < 256; i++) m_known[k][i] = 0;
    model_reset();
    tick();
    do_reset("init");

    // Basic write then read-back of address 5 (out of range on the DEPTH=4 instance).
    load(1, 5, 0, 0);
    load(0, 0, 1, 'h1234);
    strobe(1, 0, "wr5");
    load(1, 5, 0, 0);
    strobe(0, 1, "rd5");

    // Missing operands and rejected combinations.
    load(1, 5, 0, 0);
    strobe(1, 0, "wr_no_d");
    strobe(1, 1, "wr_rd_bad");
    load(0, 0, 1, 'h0321);
    strobe(1, 1, "wr_rd_prio");
    do_reset("noload");
    strobe(0, 1, "rd_no_a");

    // Out-of-range write leaves address 44 alone.
    load(1, 44, 1, 'h0155);
    strobe(1, 0, "wr44");
    load(1, 300, 1, 'h7eee);
    strobe(1, 0, "wr300");
    load(1, 44, 0, 0);
    strobe(0, 1, "rd44");
    load(1, 300, 0, 0);
    strobe(0, 1, "rd300");

    // Sweeps: DEPTH=4 instance saturates pass at 15 and keeps pulsing finish.
    do_reset("sweep");
    for (int s = 0; s < 17; s++)
      for (int a = 0; a < 4; a++) begin
        load(1, a, 1, int'($urandom_range(0, 32767)));
        strobe(1, 0, $sformatf("sw%0d_%0d", s, a));
      end

    // Strobe while busy is flagged but does not disturb the write.
    load(1, 2, 1, 'h0abc);
    write = 1'b1;
    tick();
    write = 1'b0;
    read  = 1'b1;
    check_flags("busy_t1", 0, 1, 0);
    tick();
    read = 1'b0;
    check_flags("busy_t2", 0, 1, 1);
    tick();
    write_resp("busy_wr");
    tick();
    load(1, 2, 0, 0);
    strobe(0, 1, "busy_rd");

    // Reset during a write: no commit, no done.
    load(1, 3, 1, 'h7777);
    write = 1'b1;
    tick();
    write = 1'b0;
    rst   = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("abort_busy%0d", k), 32'(busy_o[k]), 0);
      check($sformatf("abort_pass%0d", k), 32'(pass_o[k]), 0);
      check($sformatf("abort_done%0d", k), 32'(done_o[k]), 0);
    end
    model_reset();
    for (int c = 0; c < 4; c++) begin
      tick();
      check_flags($sformatf("abort_post%0d", c), 0, 0, 0);
    end
    load(1, 3, 0, 0);
    strobe(0, 1, "abort_rd");

    // Randomized mix of loads, strobes and addresses around both depths.
    for (int it = 0; it < 120; it++) begin
      bit la, ld, wr, rd;
      int a;
      la = 1'($urandom_range(0, 1));
      ld = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       a = int'($urandom_range(0, 3));
        1:       a = int'($urandom_range(0, 255));
        2:       a = int'($urandom_range(256, 400));
        default: a = int'($urandom_range(0, 32767));
      endcase
      if (la || ld) load(la, a, ld, int'($urandom_range(0, 32767)));
      strobe(wr, rd, $sformatf("rnd%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
